axi_mem_resp_model: RTL and testbench

Responder end of the simplified AXI port that the DDR BIST initiator drives, standing in for the DDR controller. It accepts write and read bursts and stores data in a local RAM. Read data is returned after a fixed latency. Used for on-chip loopback and simulation of the BIST without a DDR device; optional wready throttling exercises the initiator's stall handling.

---
 rtl/axi_mem_resp_model.sv | 191 +++++++++++++++++++
 tb/tb_axi_mem_resp_model.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_resp_model.sv
// Responder end of the simplified AXI port: stores write bursts in a local RAM and
// returns read bursts after a fixed latency, with optional pseudo-random wready stalls.
module axi_mem_resp_model #(
  parameter int unsigned CTRL_ADDR_WIDTH = 28,
  parameter int unsigned MEM_DQ_WIDTH    = 16,
  parameter int unsigned LOCAL_AW        = 8,
  parameter int unsigned RD_LATENCY      = 4,
  parameter bit          STALL_EN        = 1'b0,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                         core_clk,
  input  logic                         core_clk_rst,
  input  logic [CTRL_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic                         axi_awuser_ap,
  input  logic [3:0]                   axi_awuser_id,
  input  logic [3:0]                   axi_awlen,
  input  logic                         axi_awvalid,
  output logic                         axi_awready,
  input  logic [MEM_DQ_WIDTH*8-1:0]    axi_wdata,
  input  logic [MEM_DQ_WIDTH-1:0]      axi_wstrb,
  output logic                         axi_wready,
  input  logic [CTRL_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic                         axi_aruser_ap,
  input  logic [3:0]                   axi_aruser_id,
  input  logic [3:0]                   axi_arlen,
  input  logic                         axi_arvalid,
  output logic                         axi_arready,
  output logic [MEM_DQ_WIDTH*8-1:0]    axi_rdata,
  output logic [3:0]                   axi_rid,
  output logic                         axi_rlast,
  output logic                         axi_rvalid,
  output logic [3:0]                   last_wr_id,
  output logic [15:0]                  wr_burst_cnt,
  output logic [15:0]                  rd_burst_cnt,
  output logic [1:0]                   resp_state
);

  localparam int unsigned DW    = MEM_DQ_WIDTH * 8;
  localparam int unsigned IW    = LOCAL_AW;
  localparam int unsigned DEPTH = 1 << LOCAL_AW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_DATA = 2'd1,
    RD_WAIT = 2'd2,
    RD_DATA = 2'd3
  } state_t;

  state_t        state;
  logic          pri_wr;
  logic [15:0]   lfsr;
  logic [15:0]   lfsr_nxt;
  logic          stall_nxt;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [4:0]    wr_left;
  logic [4:0]    rd_left;
  logic [3:0]    lat_cnt;
  logic [IW-1:0] aw_idx;
  logic [IW-1:0] ar_idx;
  logic          aw_hs;
  logic          ar_hs;
  logic          mem_we;
  logic [DW-1:0] mem [DEPTH];

  assign aw_idx = axi_awaddr[LOCAL_AW+2:3];
  assign ar_idx = axi_araddr[LOCAL_AW+2:3];

  // Round-robin grant; only one ready can be high, and only while idle.
  assign axi_awready = ~core_clk_rst & (state == IDLE) & axi_awvalid & (pri_wr | ~axi_arvalid);
  assign axi_arready = ~core_clk_rst & (state == IDLE) & axi_arvalid & (~pri_wr | ~axi_awvalid);
  assign aw_hs       = axi_awready;
  assign ar_hs       = axi_arready;
  assign mem_we      = (state == WR_DATA) & axi_wready;
  assign resp_state  = state;

  // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1; bit 0 of the next value decides a stall.
  always_comb begin
    lfsr_nxt  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    stall_nxt = STALL_EN & lfsr_nxt[0];
  end

  // Byte-masked RAM write; contents survive reset.
  always_ff @(posedge core_clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(MEM_DQ_WIDTH); b++) begin
        if (axi_wstrb[b]) mem[wr_idx][b*8 +: 8] <= axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge core_clk or posedge core_clk_rst) begin
    if (core_clk_rst) begin
      state        <= IDLE;
      pri_wr       <= 1'b1;
      lfsr         <= LFSR_SEED;
      wr_idx       <= '0;
      rd_idx       <= '0;
      wr_left      <= '0;
      rd_left      <= '0;
      lat_cnt      <= '0;
      axi_wready   <= 1'b0;
      axi_rvalid   <= 1'b0;
      axi_rlast    <= 1'b0;
      axi_rdata    <= '0;
      axi_rid      <= '0;
      last_wr_id   <= '0;
      wr_burst_cnt <= '0;
      rd_burst_cnt <= '0;
    end else begin
      if (STALL_EN) lfsr <= lfsr_nxt;
      case (state)
        IDLE: begin
          if (aw_hs) begin
            wr_idx       <= aw_idx;
            wr_left      <= {1'b0, axi_awlen} + 5'd1;
            last_wr_id   <= axi_awuser_id;
            wr_burst_cnt <= wr_burst_cnt + 16'd1;
            pri_wr       <= ~pri_wr;
            axi_wready   <= ~stall_nxt;
            state        <= WR_DATA;
          end else if (ar_hs) begin
            axi_rid <= axi_aruser_id;
            pri_wr  <= ~pri_wr;
            if (RD_LATENCY <= 1) begin
              // Single-cycle latency launches the first beat from the handshake itself.
              axi_rdata  <= mem[ar_idx];
              rd_idx     <= ar_idx + IW'(1);
              rd_left    <= {1'b0, axi_arlen};
              axi_rlast  <= (axi_arlen == 4'd0);
              axi_rvalid <= 1'b1;
              state      <= RD_DATA;
            end else begin
              rd_idx  <= ar_idx;
              rd_left <= {1'b0, axi_arlen} + 5'd1;
              lat_cnt <= 4'(RD_LATENCY - 1);
              state   <= RD_WAIT;
            end
          end
        end
        WR_DATA: begin
          if (axi_wready) begin
            wr_idx  <= wr_idx + IW'(1);
            wr_left <= wr_left - 5'd1;
            if (wr_left == 5'd1) begin
              axi_wready <= 1'b0;
              state      <= IDLE;
            end else begin
              axi_wready <= ~stall_nxt;
            end
          end else begin
            axi_wready <= ~stall_nxt;
          end
        end
        RD_WAIT: begin
          if (lat_cnt == 4'd1) begin
            axi_rdata  <= mem[rd_idx];
            rd_idx     <= rd_idx + IW'(1);
            rd_left    <= rd_left - 5'd1;
            axi_rlast  <= (rd_left == 5'd1);
            axi_rvalid <= 1'b1;
            state      <= RD_DATA;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RD_DATA: begin
          // Master always accepts, so every rvalid cycle is a completed beat.
          if (axi_rlast) begin
            axi_rvalid   <= 1'b0;
            axi_rlast    <= 1'b0;
            rd_burst_cnt <= rd_burst_cnt + 16'd1;
            state        <= IDLE;
          end else begin
            axi_rdata <= mem[rd_idx];
            rd_idx    <= rd_idx + IW'(1);
            rd_left   <= rd_left - 5'd1;
            axi_rlast <= (rd_left == 5'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic unused_inputs;
  assign unused_inputs = ^{axi_awuser_ap, axi_aruser_ap,
                           axi_awaddr[2:0], axi_awaddr[CTRL_ADDR_WIDTH-1:LOCAL_AW+3],
                           axi_araddr[2:0], axi_araddr[CTRL_ADDR_WIDTH-1:LOCAL_AW+3]};

endmodule

// File: tb/tb_axi_mem_resp_model.sv
// Directed bench for axi_mem_resp_model: arbitration, latency, strobes, wrap, stalls, reset abort.
module tb_axi_mem_resp_model;

  localparam int unsigned AW  = 28;
  localparam int unsigned DQ  = 16;
  localparam int unsigned DW  = DQ * 8;
  localparam int unsigned LAT = 4;

  logic          clk;
  logic          rst;
  logic [AW-1:0] awaddr, araddr;
  logic          awap, arap;
  logic [3:0]    awid, arid, awlen, arlen;
  logic          awvalid, awready, arvalid, arready;
  logic [DW-1:0] wdata, rdata;
  logic [DQ-1:0] wstrb;
  logic          wready, rlast, rvalid;
  logic [3:0]    rid, last_wr_id;
  logic [15:0]   wr_cnt, rd_cnt;
  logic [1:0]    st;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            gaps;
  logic [DW-1:0] wd [16];
  logic [DW-1:0] re [16];
  logic [DQ-1:0] ws [16];

  axi_mem_resp_model #(
    .CTRL_ADDR_WIDTH(AW),
    .MEM_DQ_WIDTH   (DQ),
    .LOCAL_AW       (8),
    .RD_LATENCY     (LAT),
    .STALL_EN       (1'b1),
    .LFSR_SEED      (16'hACE1)
  ) dut (
    .core_clk     (clk),
    .core_clk_rst (rst),
    .axi_awaddr   (awaddr),
    .axi_awuser_ap(awap),
    .axi_awuser_id(awid),
    .axi_awlen    (awlen),
    .axi_awvalid  (awvalid),
    .axi_awready  (awready),
    .axi_wdata    (wdata),
    .axi_wstrb    (wstrb),
    .axi_wready   (wready),
    .axi_araddr   (araddr),
    .axi_aruser_ap(arap),
    .axi_aruser_id(arid),
    .axi_arlen    (arlen),
    .axi_arvalid  (arvalid),
    .axi_arready  (arready),
    .axi_rdata    (rdata),
    .axi_rid      (rid),
    .axi_rlast    (rlast),
    .axi_rvalid   (rvalid),
    .last_wr_id   (last_wr_id),
    .wr_burst_cnt (wr_cnt),
    .rd_burst_cnt (rd_cnt),
    .resp_state   (st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic aw_req(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id);
    awaddr = a; awlen = len; awid = id; awvalid = 1'b1;
  endtask

  task automatic ar_req(input logic [AW-1:0] a, input logic [3:0] len, input logic [3:0] id);
    araddr = a; arlen = len; arid = id; arvalid = 1'b1;
  endtask

  // Returns at the falling edge just after the AW handshake edge.
  task automatic aw_wait();
    int n = 0;
    #1;
    while (!awready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("aw_grant", 128'(awready), 128'(1));
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic ar_wait();
    int n = 0;
    #1;
    while (!arready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("ar_grant", 128'(arready), 128'(1));
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  // Presents wd[beat] continuously; a beat is consumed on each edge that sees wready high.
  task automatic w_data(input int n);
    int cnt = 0;
    int cyc = 0;
    gaps = 0;
    while (cnt < n && cyc < 400) begin
      wdata = wd[cnt]; wstrb = ws[cnt];
      #1;
      if (wready) cnt++;
      else if (cnt > 0) gaps++;
      @(negedge clk);
      cyc++;
    end
    chk("w_beats", 128'(cnt), 128'(n));
    chk("w_done_wready", 128'(wready), 128'(0));
    chk("w_done_state", 128'(st), 128'(0));
  endtask

  // Entered at the first falling edge after the AR handshake edge (latency count 1).
  task automatic r_data(input int n, input logic [3:0] id);
    int k = 1;
    while (!rvalid && k < 40) begin
      @(negedge clk); k++;
    end
    chk("r_latency", 128'(k), 128'(LAT));
    for (int b = 0; b < n; b++) begin
      chk($sformatf("r_valid%0d", b), 128'(rvalid), 128'(1));
      chk($sformatf("r_data%0d", b), rdata, re[b]);
      chk($sformatf("r_last%0d", b), 128'(rlast), 128'(b == n - 1));
      chk($sformatf("r_id%0d", b), 128'(rid), 128'(id));
      @(negedge clk);
    end
    chk("r_end_valid", 128'(rvalid), 128'(0));
    chk("r_end_last", 128'(rlast), 128'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [7:0] bv;
    rst = 1'b1;
    awaddr = '0; araddr = '0; awap = 1'b0; arap = 1'b0;
    awid = '0; arid = '0; awlen = '0; arlen = '0;
    awvalid = 1'b0; arvalid = 1'b0; wdata = '0; wstrb = '0;
    repeat (3) @(negedge clk);

    chk("rst_awready", 128'(awready), 128'(0));
    chk("rst_arready", 128'(arready), 128'(0));
    chk("rst_wready", 128'(wready), 128'(0));
    chk("rst_rvalid", 128'(rvalid), 128'(0));
    chk("rst_rlast", 128'(rlast), 128'(0));
    chk("rst_rdata", rdata, 128'(0));
    chk("rst_rid", 128'(rid), 128'(0));
    chk("rst_last_wr_id", 128'(last_wr_id), 128'(0));
    chk("rst_wr_cnt", 128'(wr_cnt), 128'(0));
    chk("rst_rd_cnt", 128'(rd_cnt), 128'(0));
    chk("rst_state", 128'(st), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    // Simultaneous AW/AR from reset: write first, then the pending read beats a new write.
    for (int i = 0; i < 4; i++) begin
      bv = 8'(8'h11 * (i + 1));
      wd[i] = {16{bv}}; ws[i] = '1; re[i] = wd[i];
    end
    aw_req(28'h40, 4'd3, 4'h5);
    ar_req(28'h40, 4'd3, 4'h9);
    #1;
    chk("arb_aw_first", 128'(awready), 128'(1));
    chk("arb_ar_blocked", 128'(arready), 128'(0));
    aw_wait();
    chk("ar_blocked_in_wr", 128'(arready), 128'(0));
    aw_req(28'h7F0, 4'd3, 4'hA);
    w_data(4);
    #1;
    chk("arb_ar_second", 128'(arready), 128'(1));
    chk("arb_aw_second", 128'(awready), 128'(0));
    chk("last_wr_id_1", 128'(last_wr_id), 128'(5));
    chk("wr_cnt_1", 128'(wr_cnt), 128'(1));
    ar_wait();
    r_data(4, 4'h9);
    chk("wr_cnt_after_rd", 128'(wr_cnt), 128'(1));
    chk("rd_cnt_after_rd", 128'(rd_cnt), 128'(1));
    chk("aw_after_rd", 128'(awready), 128'(1));

    // Index 254, 4 beats: wraps to 0 and 1.
    for (int i = 0; i < 4; i++) begin
      wd[i] = {4{32'hA5A50000 + 32'(i)}}; ws[i] = '1; re[i] = wd[i];
    end
    aw_wait();
    w_data(4);
    chk("last_wr_id_2", 128'(last_wr_id), 128'(4'hA));
    chk("wr_cnt_2", 128'(wr_cnt), 128'(2));
    ar_req(28'h7F0, 4'd3, 4'h3);
    ar_wait();
    r_data(4, 4'h3);
    re[0] = wd[2]; re[1] = wd[3];
    ar_req(28'h0, 4'd1, 4'h4);
    ar_wait();
    r_data(2, 4'h4);

    // Byte strobe: only byte 0 cleared; also a single-beat burst.
    wd[0] = '1; ws[0] = '1;
    aw_req(28'h100, 4'd0, 4'h1);
    aw_wait();
    w_data(1);
    wd[0] = '0; ws[0] = 16'h0001;
    aw_req(28'h100, 4'd0, 4'h2);
    aw_wait();
    w_data(1);
    re[0] = {{120{1'b1}}, 8'h00};
    ar_req(28'h100, 4'd0, 4'h6);
    ar_wait();
    r_data(1, 4'h6);

    // 16-beat write under wready stalls.
    for (int i = 0; i < 16; i++) begin
      wd[i] = {4{32'hDEAD0000 | 32'(i)}}; ws[i] = '1; re[i] = wd[i];
    end
    aw_req(28'h400, 4'd15, 4'h7);
    aw_wait();
    w_data(16);
    chk("stall_gaps_seen", 128'(gaps > 0), 128'(1));
    ar_req(28'h400, 4'd15, 4'h8);
    ar_wait();
    r_data(16, 4'h8);
    chk("wr_cnt_3", 128'(wr_cnt), 128'(5));
    chk("rd_cnt_3", 128'(rd_cnt), 128'(5));

    // Reset during beat 2 of an 8-beat read.
    ar_req(28'h400, 4'd7, 4'hC);
    ar_wait();
    k = 0;
    while (!rvalid && k < 40) begin
      @(negedge clk); k++;
    end
    @(negedge clk);
    chk("abort_beat2_valid", 128'(rvalid), 128'(1));
    chk("abort_beat2_data", rdata, wd[1]);
    rst = 1'b1;
    #1;
    chk("abort_rvalid", 128'(rvalid), 128'(0));
    chk("abort_rlast", 128'(rlast), 128'(0));
    chk("abort_wr_cnt", 128'(wr_cnt), 128'(0));
    chk("abort_rd_cnt", 128'(rd_cnt), 128'(0));
    chk("abort_state", 128'(st), 128'(0));
    @(negedge clk);
    chk("abort_rvalid_edge", 128'(rvalid), 128'(0));
    rst = 1'b0;
    @(negedge clk);

    re[0] = wd[0]; re[1] = wd[1];
    ar_req(28'h400, 4'd1, 4'h2);
    ar_wait();
    r_data(2, 4'h2);
    chk("post_rst_rd_cnt", 128'(rd_cnt), 128'(1));
    chk("post_rst_wr_cnt", 128'(wr_cnt), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
